// File: rtl/uart_frame_assembler_if.sv
// Handshake bundle between the UART byte source, the frame assembler and the
// downstream frame consumer. The producer side (byte strobe, byte, ack) is the
// master; the assembler is the slave.
interface uart_frame_assembler_if #(
    parameter int FRAME_W = 16
);
    logic               in_uart_ready;
    logic [7:0]         in_uart_frame;
    logic               in_ack;
    logic [FRAME_W-1:0] out_frame;
    logic               out_valid;
    logic               out_overrun;
    logic               out_resync;

    modport master (
        output in_uart_ready,
        output in_uart_frame,
        output in_ack,
        input  out_frame,
        input  out_valid,
        input  out_overrun,
        input  out_resync
    );

    modport slave (
        input  in_uart_ready,
        input  in_uart_frame,
        input  in_ack,
        output out_frame,
        output out_valid,
        output out_overrun,
        output out_resync
    );
endinterface

// File: rtl/uart_frame_assembler.sv
// UART-byte-to-sample-frame packer. Collects BPS/8 bytes per sample and
// FRAME_SIZE samples per frame, places bytes according to BIG_ENDIAN, drops
// half-built frames after an inter-byte timeout and hands each finished frame
// to a valid/ack output register. A finished frame that finds the output
// register still occupied is dropped and reported on out_overrun.
module uart_frame_assembler #(
    parameter int BPS          = 16,
    parameter int FRAME_SIZE   = 1,
    parameter int BIG_ENDIAN   = 1,
    parameter int TIMEOUT_CLKS = 0
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    uart_frame_assembler_if.slave   bus
);
    localparam int BYTES   = BPS / 8;
    localparam int FRAME_W = FRAME_SIZE * BPS;
    localparam int BCW     = (BYTES > 1)        ? $clog2(BYTES)          : 1;
    localparam int SCW     = (FRAME_SIZE > 1)   ? $clog2(FRAME_SIZE)     : 1;
    localparam int IW      = (FRAME_W > 1)      ? $clog2(FRAME_W)        : 1;
    localparam int TW      = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS+1) : 1;

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [SCW-1:0] LAST_SAMP = SCW'(FRAME_SIZE - 1);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CLKS);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t               state_q;
    logic [BCW-1:0]       byte_cnt_q;
    logic [SCW-1:0]       samp_cnt_q;
    logic [TW-1:0]        timer_q;
    logic [FRAME_W-1:0]   asm_q;
    logic [FRAME_W-1:0]   frame_q;
    logic                 valid_q;
    logic                 overrun_q;
    logic                 resync_q;

    logic [BCW-1:0]       lane_d;
    logic [IW-1:0]        bit_idx_d;
    logic [FRAME_W-1:0]   merged_d;
    logic                 last_byte_d;
    logic                 out_free_d;
    logic [TW-1:0]        timer_inc_d;
    logic                 expire_d;

    // Where the incoming byte lands, the buffer with it merged in, and the
    // frame-complete / output-free / timeout-expiry decisions for this cycle.
    always_comb begin
        lane_d      = (BIG_ENDIAN != 0) ? (LAST_BYTE - byte_cnt_q) : byte_cnt_q;
        bit_idx_d   = IW'(samp_cnt_q) * IW'(BPS) + IW'(lane_d) * IW'(8);
        merged_d    = asm_q;
        merged_d[bit_idx_d +: 8] = bus.in_uart_frame;
        last_byte_d = (byte_cnt_q == LAST_BYTE) && (samp_cnt_q == LAST_SAMP);
        out_free_d  = !valid_q || bus.in_ack;
        timer_inc_d = timer_q + TW'(1);
        // Expiry is the cycle the idle count would reach TIMEOUT_CLKS, so the
        // resync pulse appears exactly TIMEOUT_CLKS clocks after the last strobe.
        expire_d    = (TIMEOUT_CLKS > 0) && (state_q == S_COLLECT) &&
                      (timer_inc_d == TIMER_MAX);
    end

    // Assembly FSM with its counters, idle timer and all registered outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            samp_cnt_q <= '0;
            timer_q    <= '0;
            asm_q      <= '0;
            frame_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            resync_q  <= 1'b0;

            // Consumer handshake; a frame loaded below in the same cycle keeps
            // valid high with no bubble.
            if (valid_q && bus.in_ack) begin
                valid_q <= 1'b0;
            end

            if (bus.in_uart_ready) begin
                // A strobe always wins over a coincident timeout expiry.
                timer_q <= '0;
                if (last_byte_d) begin
                    state_q    <= S_IDLE;
                    byte_cnt_q <= '0;
                    samp_cnt_q <= '0;
                    asm_q      <= '0;
                    if (out_free_d) begin
                        frame_q <= merged_d;
                        valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end else begin
                    state_q <= S_COLLECT;
                    asm_q   <= merged_d;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_q <= '0;
                        samp_cnt_q <= samp_cnt_q + SCW'(1);
                    end else begin
                        byte_cnt_q <= byte_cnt_q + BCW'(1);
                    end
                end
            end else if (expire_d) begin
                state_q    <= S_IDLE;
                byte_cnt_q <= '0;
                samp_cnt_q <= '0;
                asm_q      <= '0;
                timer_q    <= '0;
                resync_q   <= 1'b1;
            end else if ((TIMEOUT_CLKS > 0) && (state_q == S_COLLECT)) begin
                if (timer_q != TIMER_MAX) begin
                    timer_q <= timer_inc_d;
                end else begin
                    timer_q <= timer_q;
                end
            end else begin
                timer_q <= '0;
            end
        end
    end

    assign bus.out_frame   = frame_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_overrun = overrun_q;
    assign bus.out_resync  = resync_q;

endmodule
